// File: rtl/mdu_pkg.sv
// Shared types, iteration count and negation helpers for the multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_ITER = 32;
  localparam int unsigned CNT_W    = $clog2(MDU_ITER);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FINISH
  } mdu_state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module mdu_div_step (
  input  logic [32:0] rem_in,
  input  logic [31:0] divisor,
  input  logic        dividend_bit,
  output logic [32:0] rem_out,
  output logic        q_bit
);

  logic [33:0] diff;

  // {rem_in, bit} never exceeds 2^33, so bit 33 of the difference is the borrow.
  always_comb begin
    diff    = {rem_in, dividend_bit} - {2'b00, divisor};
    q_bit   = ~diff[33];
    rem_out = q_bit ? diff[32:0] : {rem_in[31:0], dividend_bit};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Define MDU_DIV_EN to compile in the divider; otherwise DIV/DIVU report divide-by-zero.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  mdu_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      mcand;
  logic [63:0]      prod;
  logic             neg_res, dz;
  logic [31:0]      hi_r, lo_r;
  logic             busy_r, done_r, div_zero_r;

  mdu_op_t     op_e;
  logic        sgn, last_iter;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum;
  logic [63:0] prod_next, prod_fix;
  logic [31:0] fin_hi, fin_lo;

`ifdef MDU_DIV_EN
  logic [31:0] dvsr;
  logic [32:0] rem;
  logic [31:0] quo;
  logic        neg_rem, is_div;
  logic [32:0] step_rem;
  logic        step_q;

  mdu_div_step u_div_step (
    .rem_in       (rem),
    .divisor      (dvsr),
    .dividend_bit (quo[31]),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );
`endif

  always_comb begin
    op_e      = mdu_op_t'(op);
    sgn       = (op_e == OP_MULT) || (op_e == OP_DIV);
    a_abs     = (sgn && a_in[31]) ? neg32(a_in) : a_in;
    b_abs     = (sgn && b_in[31]) ? neg32(b_in) : b_in;
    last_iter = (cnt == CNT_W'(MDU_ITER - 1));
    // Multiplier sits in the low half and shifts out as the product shifts in.
    mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
    prod_next = {mul_sum, prod[31:1]};
    prod_fix  = neg_res ? neg64(prod) : prod;
    fin_hi    = prod_fix[63:32];
    fin_lo    = prod_fix[31:0];
`ifdef MDU_DIV_EN
    if (is_div) begin
      fin_hi = neg_rem ? neg32(rem[31:0]) : rem[31:0];
      fin_lo = neg_res ? neg32(quo) : quo;
    end
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (op[1]) begin
`ifdef MDU_DIV_EN
            state_next = (b_in == '0) ? ST_FINISH : ST_DIV;
`else
            state_next = ST_FINISH;
`endif
          end else begin
            state_next = ST_MUL;
          end
        end
      end
      ST_MUL:    if (last_iter) state_next = ST_FINISH;
`ifdef MDU_DIV_EN
      ST_DIV:    if (last_iter) state_next = ST_FINISH;
`endif
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      mcand      <= '0;
      prod       <= '0;
      neg_res    <= 1'b0;
      dz         <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
`ifdef MDU_DIV_EN
      dvsr       <= '0;
      rem        <= '0;
      quo        <= '0;
      neg_rem    <= 1'b0;
      is_div     <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      busy_r     <= (state_next != ST_IDLE);
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt     <= '0;
            mcand   <= b_abs;
            prod    <= {32'd0, a_abs};
            neg_res <= sgn & (a_in[31] ^ b_in[31]);
`ifdef MDU_DIV_EN
            dz      <= op[1] & (b_in == '0);
            is_div  <= op[1];
            dvsr    <= b_abs;
            rem     <= '0;
            quo     <= a_abs;
            neg_rem <= sgn & a_in[31];
`else
            dz      <= op[1];
`endif
          end
        end
        ST_MUL: begin
          prod <= prod_next;
          cnt  <= cnt + CNT_W'(1);
        end
`ifdef MDU_DIV_EN
        ST_DIV: begin
          rem <= step_rem;
          quo <= {quo[30:0], step_q};
          cnt <= cnt + CNT_W'(1);
        end
`endif
        ST_FINISH: begin
          done_r     <= 1'b1;
          div_zero_r <= dz;
          if (!dz) begin
            hi_r <= fin_hi;
            lo_r <= fin_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi       = hi_r;
  assign lo       = lo_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus scoreboard, with reset/ignore-start sequences.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] a_in, b_in;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  mult_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        dz;
    logic [31:0] hi, lo;
    bit          b2b;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    logic        dz;
  } res_t;

  vec_t vecs[$];
  res_t sb[$];
  int   n_pass = 0, n_total = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void add(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                              input logic z, input logic [31:0] h, input logic [31:0] l, input bit bb);
    vec_t v;
`ifndef MDU_DIV_EN
    if (o[1]) z = 1'b1;
`endif
    v.op = o; v.a = x; v.b = y; v.dz = z; v.hi = h; v.lo = l; v.b2b = bb;
    vecs.push_back(v);
  endfunction

  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint p;
    int     sx, sy;
    z = 1'b0; h = '0; l = '0;
    sx = x; sy = y;
    case (o)
      2'b00: begin p = longint'(sx) * longint'(sy); {h, l} = p; end
      2'b01: begin p = longint'({32'd0, x}) * longint'({32'd0, y}); {h, l} = p; end
      2'b10: if (y == 0) z = 1'b1; else begin l = sx / sy; h = sx % sy; end
      default: if (y == 0) z = 1'b1; else begin l = x / y; h = x % y; end
    endcase
`ifndef MDU_DIV_EN
    if (o[1]) z = 1'b1;
`endif
  endfunction

  // Issues one operation starting in the current (negedge) cycle; returns at the negedge of the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic z, input logic [31:0] h, input logic [31:0] l,
                        input int glitch, input string tag);
    res_t r, got;
    int   n, exp_lat;
    bit   hold_ok;
    start = 1'b1; op = o; a_in = x; b_in = y;
    r.dz = z;
    r.hi = z ? m_hi : h;
    r.lo = z ? m_lo : l;
    sb.push_back(r);
    exp_lat = z ? 2 : 34;
    n = 0; hold_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (glitch > 1 && n == glitch) begin
        start = 1'b1; op = OP_MULTU; a_in = 32'd100; b_in = 32'd100;
      end else if (glitch > 1 && n == glitch + 1) begin
        start = 1'b0;
      end
      if (!done && (!busy || hi !== m_hi || lo !== m_lo)) hold_ok = 1'b0;
    end while (!done && n < 60);
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy/hold"}, {31'd0, hold_ok}, 32'd1);
    check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check({tag, " hi"}, hi, got.hi);
      check({tag, " lo"}, lo, got.lo);
      check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, got.dz});
      m_hi = got.hi; m_lo = got.lo;
    end
  endtask

  task automatic count_done(input int cycles, input string tag);
    int pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check({tag, " no done pulse"}, pulses, 0);
  endtask

  initial begin
    logic [31:0] rx, ry, rh, rl;
    logic        rz;
    logic [1:0]  ro;

    add(OP_MULT,  32'd7,        32'hFFFFFFFD, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    add(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 32'h00000001, 0);
    add(OP_MULT,  32'd3,        32'd4,        0, 32'd0,        32'd12,       1);
    add(OP_MULT,  32'h80000000, 32'd2,        0, 32'hFFFFFFFF, 32'h00000000, 0);
    add(OP_MULTU, 32'h80000000, 32'd2,        0, 32'd1,        32'd0,        0);
    add(OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'd0,        32'd1,        0);
    add(OP_DIV,   32'hFFFFFFF9, 32'd2,        0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    add(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 32'd0,        32'h80000000, 0);
    add(OP_DIVU,  32'd100,      32'd7,        0, 32'd2,        32'd14,       0);
    add(OP_DIV,   32'd7,        32'hFFFFFFFE, 0, 32'd1,        32'hFFFFFFFD, 0);
    add(OP_DIVU,  32'd65,       32'd10,       0, 32'd5,        32'd6,        0);
    add(OP_DIVU,  32'd100,      32'd0,        1, 32'd0,        32'd0,        0);
    add(OP_DIV,   32'd10,       32'd2,        0, 32'd0,        32'd5,        1);
    add(OP_MULT,  32'd6,        32'd7,        0, 32'd0,        32'd42,       0);
    add(OP_DIV,   32'd5,        32'd0,        1, 32'd0,        32'd0,        1);
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom; ry = $urandom;
      if (ro[1] && (i % 2 == 1)) ry = $urandom_range(1, 1000);
      if (ro == 2'b10 && ry == 32'hFFFFFFFF) ry = 32'd3;
      model(ro, rx, ry, rh, rl, rz);
      add(ro, rx, ry, rz, rh, rl, 0);
    end

    reset = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset div_zero", {31'd0, div_zero}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      if (!vecs[i].b2b) repeat (2) @(negedge clk);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dz, vecs[i].hi, vecs[i].lo, 0,
             $sformatf("vec%0d", i));
    end

    // start pulsed mid-operation with different operands must be ignored
    repeat (2) @(negedge clk);
    run_op(OP_MULT, 32'd3, 32'd5, 0, 32'd0, 32'd15, 5, "ignore start");

    // reset in cycle 10 of a running multiply
    repeat (2) @(negedge clk);
    start = 1'b1; op = OP_MULT; a_in = 32'd9; b_in = 32'd9;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 10) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    check("midreset hi", hi, 32'd0);
    check("midreset lo", lo, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset div_zero", {31'd0, div_zero}, 32'd0);
    m_hi = '0; m_lo = '0;
    count_done(40, "midreset");

    // reset and start in the same cycle: start is dropped
    start = 1'b1; reset = 1'b1; op = OP_MULT; a_in = 32'd2; b_in = 32'd2;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("reset+start busy", {31'd0, busy}, 32'd0);
    count_done(40, "reset+start");

    run_op(OP_MULT, 32'd2, 32'd3, 0, 32'd0, 32'd6, 0, "post reset");
    check("scoreboard empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
